ps2_scan_decoder: RTL and testbench

//  Receives raw PS/2 keyboard frames and turns them into single-cycle make-code events
//  (8-bit code plus one-cycle ready strobe) for the Pac-Man direction controller.

---
 rtl/ps2_scan_decoder.sv | 118 +++++++++++
 tb/tb_ps2_scan_decoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: PS/2 keyboard frame receiver emitting single-cycle make-code events
module ps2_scan_decoder #(
  parameter int TIMEOUT_CYC = 200000,
  parameter bit FILTER_DIRS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboardCode,
  output logic       ps2_ready,
  output logic       ext_key,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  state_t state, state_n;
  logic [2:0] pc_s;
  logic [1:0] pd_s;
  logic [3:0] cnt, cnt_n;
  logic [9:0] sh, sh_n;
  logic [TW-1:0] tmo, tmo_n;
  logic ext_f, ext_n, brk_f, brk_n;
  logic [7:0] code_n;
  logic ek_n, rdy_n, err_n;
  logic fall, d, ok, ign, dir;
  logic [7:0] b;
  assign fall = pc_s[2] & ~pc_s[1];
  assign d = pd_s[1];
  assign b = sh[7:0];
  assign ok = (^sh[8:0]) & sh[9];
  assign ign = b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hE1};
  assign dir = b inside {8'h6B, 8'h74, 8'h75, 8'h72};
  // state register, input synchronizers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_s <= 3'b111;
      pd_s <= 2'b11;
      cnt <= '0;
      sh <= '0;
      tmo <= '0;
      ext_f <= 1'b0;
      brk_f <= 1'b0;
      keyboardCode <= 8'h00;
      ext_key <= 1'b0;
      ps2_ready <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      pc_s <= {pc_s[1:0], ps2_clk};
      pd_s <= {pd_s[0], ps2_data};
      cnt <= cnt_n;
      sh <= sh_n;
      tmo <= tmo_n;
      ext_f <= ext_n;
      brk_f <= brk_n;
      keyboardCode <= code_n;
      ext_key <= ek_n;
      ps2_ready <= rdy_n;
      frame_err <= err_n;
    end
  end
  // frame reception, timeout, validity check and prefix/break decoding
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    tmo_n = tmo;
    ext_n = ext_f;
    brk_n = brk_f;
    code_n = keyboardCode;
    ek_n = ext_key;
    rdy_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (fall && !d) begin
        state_n = RECV;
        cnt_n = '0;
        tmo_n = '0;
      end
      RECV: if (fall) begin
        sh_n = {d, sh[9:1]};
        cnt_n = cnt + 4'd1;
        tmo_n = '0;
        state_n = (cnt == 4'd9) ? CHECK : RECV;
      end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
        state_n = IDLE;
        err_n = 1'b1;
        ext_n = 1'b0;
        brk_n = 1'b0;
      end else begin
        tmo_n = tmo + 1'b1;
      end
      CHECK: begin
        state_n = IDLE;
        if (!ok) begin
          err_n = 1'b1;
          ext_n = 1'b0;
          brk_n = 1'b0;
        end else if (b == 8'hE0) begin
          ext_n = 1'b1;
        end else if (b == 8'hF0) begin
          brk_n = 1'b1;
        end else if (!ign) begin
          ext_n = 1'b0;
          brk_n = 1'b0;
          if (!brk_f && (!FILTER_DIRS || dir)) begin
            code_n = b;
            ek_n = ext_f;
            rdy_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: scoreboard bench driving filtered and unfiltered decoders from one PS/2 bus
module tb_ps2_scan_decoder;
  localparam int TMO = 200;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] kc1, kc0;
  logic rdy1, rdy0, ek1, ek0, fe1, fe0;
  int compared = 0, mismatched = 0;
  typedef struct {bit err; logic [7:0] code; logic ext;} ev_t;
  ev_t q1[$], q0[$];
  bit m_ext[2], m_brk[2], m_eo[2];
  logic [7:0] m_code[2];

  ps2_scan_decoder #(.TIMEOUT_CYC(TMO), .FILTER_DIRS(1'b1)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboardCode(kc1), .ps2_ready(rdy1), .ext_key(ek1), .frame_err(fe1));
  ps2_scan_decoder #(.TIMEOUT_CYC(TMO), .FILTER_DIRS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboardCode(kc0), .ps2_ready(rdy0), .ext_key(ek0), .frame_err(fe0));

  always #5 clk = ~clk;

  task automatic push(input int f, input ev_t e);
    if (f == 1) q1.push_back(e);
    else q0.push_back(e);
  endtask

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      m_ext[f] = 0; m_brk[f] = 0; m_eo[f] = 0; m_code[f] = 8'h00;
    end
  endtask

  // behavioural decoder: one received byte (ok=0 means a bad frame or timeout)
  task automatic model(input logic [7:0] b, input bit ok);
    for (int f = 0; f < 2; f++) begin
      if (!ok) begin
        m_ext[f] = 0; m_brk[f] = 0;
        push(f, '{1'b1, m_code[f], m_eo[f]});
      end else if (b == 8'hE0) m_ext[f] = 1;
      else if (b == 8'hF0) m_brk[f] = 1;
      else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hE1}) begin
      end else begin
        if (!m_brk[f] && (f == 0 || b inside {8'h6B, 8'h74, 8'h75, 8'h72})) begin
          m_code[f] = b; m_eo[f] = m_ext[f];
          push(f, '{1'b0, m_code[f], m_eo[f]});
        end
        m_ext[f] = 0; m_brk[f] = 0;
      end
    end
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic expect_drained(input string name);
    compared++;
    if (q1.size() != 0 || q0.size() != 0) begin
      mismatched++;
      $display("FAIL %s: pending events filt=%0d unfilt=%0d, required 0/0", name, q1.size(), q0.size());
      q1.delete(); q0.delete();
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string name);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == 10) model(b, !bad_par && !bad_stop);
      ps2_bit(bits[i]);
    end
    ps2_data = 1'b1;
    repeat (8) @(negedge clk);
    expect_drained(name);
  endtask

  task automatic check_idle(input string name);
    compared++;
    if ({kc1, rdy1, ek1, fe1, kc0, rdy0, ek0, fe0} != 22'd0) begin
      mismatched++;
      $display("FAIL %s: got kc=%h/%h rdy=%b/%b ext=%b/%b err=%b/%b, required all zero",
               name, kc1, kc0, rdy1, rdy0, ek1, ek0, fe1, fe0);
    end
  endtask

  task automatic mon(input string name, input logic r, input logic e, input logic [7:0] kc,
                     input logic ek, inout ev_t q[$]);
    ev_t x;
    if (r && e) begin
      compared++; mismatched++;
      $display("FAIL %s_both: ready and frame_err high together", name);
    end
    if (r || e) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL %s_unexpected: got rdy=%b err=%b code=%h ext=%b, required no event", name, r, e, kc, ek);
      end else begin
        x = q.pop_front();
        if (e != x.err || kc != x.code || ek != x.ext) begin
          mismatched++;
          $display("FAIL %s_event: got err=%b code=%h ext=%b, required err=%b code=%h ext=%b",
                   name, e, kc, ek, x.err, x.code, x.ext);
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mon("filt", rdy1, fe1, kc1, ek1, q1);
      mon("unfilt", rdy0, fe0, kc0, ek0, q0);
    end
  end

  initial begin
    logic [7:0] pool [10];
    logic [7:0] b;
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h1C, 8'hFA, 8'hAA, 8'hE1};
    model_reset();
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_idle("post_reset");
    send(8'h75, 0, 0, "make_75");
    send(8'hE0, 0, 0, "e0");
    send(8'h74, 0, 0, "ext_74");
    send(8'hE0, 0, 0, "e0_b");
    send(8'hF0, 0, 0, "f0_b");
    send(8'h74, 0, 0, "break_74");
    send(8'h6B, 1, 0, "bad_parity");
    send(8'h72, 0, 1, "bad_stop");
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    model(8'h00, 0);
    repeat (TMO + 5) @(negedge clk);
    expect_drained("timeout");
    send(8'h72, 0, 0, "after_timeout");
    send(8'h1C, 0, 0, "nondir_1C");
    send(8'h75, 0, 0, "typematic_1");
    send(8'h75, 0, 0, "typematic_2");
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_idle("mid_frame_reset");
    repeat (4) @(negedge clk);
    send(8'h75, 0, 0, "after_reset");
    for (int n = 0; n < 150; n++) begin
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
      send(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, "random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
